cnt_ctrl_seq: RTL and testbench

CNT_CTRL_SEQ -- requirements
Module: cnt_ctrl_seq

---
 rtl/cnt_ctrl_seq_if.sv | 28 ++
 rtl/cnt_ctrl_seq.sv | 144 ++++++++++++++
 tb/tb_cnt_ctrl_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_ctrl_seq_if.sv
// Control bundle between a run sequencer and a 4-bit up/down counter:
// run configuration in, counter commands and run status out.
interface cnt_ctrl_seq_if #(
    parameter int DATA_W = 4
);
    logic              start;
    logic [DATA_W-1:0] presc;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] up_ticks;
    logic [DATA_W-1:0] dn_ticks;
    logic              ena;
    logic              sclr_n;
    logic              load;
    logic              dir;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;

    modport master (
        output start, presc, load_val, up_ticks, dn_ticks,
        input  ena, sclr_n, load, dir, din, busy, done
    );

    modport slave (
        input  start, presc, load_val, up_ticks, dn_ticks,
        output ena, sclr_n, load, dir, din, busy, done
    );
endinterface

// File: rtl/cnt_ctrl_seq.sv
// Sequencer that drives one clear / load / count-up / count-down run into a
// 4-bit up/down counter, pacing each command by a programmable prescaler tick.
module cnt_ctrl_seq #(
    parameter int DATA_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    cnt_ctrl_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LD,
        S_UP,
        S_DN,
        S_DONE
    } state_t;

    localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] ZERO = '0;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] presc_q;
    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] up_q;
    logic [DATA_W-1:0] dn_q;
    logic [DATA_W-1:0] pcnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] rem_nxt;
    logic              run;
    logic              tick;
    logic              accept;

    assign run    = (state == S_CLR) || (state == S_LD) ||
                    (state == S_UP)  || (state == S_DN);
    assign tick   = run && (pcnt == presc_q);
    assign accept = (state == S_IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run configuration is frozen at acceptance and only re-captured from IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            presc_q <= bus.presc;
            load_q  <= bus.load_val;
            up_q    <= bus.up_ticks;
            dn_q    <= bus.dn_ticks;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= ZERO;
            rem  <= ZERO;
        end else begin
            if (accept) begin
                pcnt <= ZERO;
            end else if (run) begin
                pcnt <= tick ? ZERO : pcnt + ONE;
            end
            rem <= rem_nxt;
        end
    end

    // State only advances on a tick so each command spans a full counter enable.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                if (tick) begin
                    state_nxt = S_LD;
                end
            end
            S_LD: begin
                if (tick) begin
                    if (up_q != ZERO) begin
                        state_nxt = S_UP;
                        rem_nxt   = up_q;
                    end else if (dn_q != ZERO) begin
                        state_nxt = S_DN;
                        rem_nxt   = dn_q;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_UP: begin
                if (tick) begin
                    if (rem == ONE) begin
                        if (dn_q != ZERO) begin
                            state_nxt = S_DN;
                            rem_nxt   = dn_q;
                        end else begin
                            state_nxt = S_DONE;
                            rem_nxt   = ZERO;
                        end
                    end else begin
                        rem_nxt = rem - ONE;
                    end
                end
            end
            S_DN: begin
                if (tick) begin
                    if (rem == ONE) begin
                        state_nxt = S_DONE;
                        rem_nxt   = ZERO;
                    end else begin
                        rem_nxt = rem - ONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                rem_nxt   = ZERO;
            end
        endcase
    end

    always_comb begin
        bus.ena    = tick;
        bus.sclr_n = (state != S_CLR);
        bus.load   = (state == S_LD);
        bus.dir    = (state == S_DN);
        bus.din    = run ? load_q : ZERO;
        bus.busy   = run;
        bus.done   = (state == S_DONE);
    end
endmodule

// File: tb/tb_cnt_ctrl_seq.sv
// Directed bench for cnt_ctrl_seq: per-cycle comparison against a run-timeline
// model, a downstream counter model, and literal per-run expectations.
module tb_cnt_ctrl_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cnt_ctrl_seq_if #(.DATA_W(4)) bus ();

    cnt_ctrl_seq #(.DATA_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Timeline model: a run is (2+u+d) ticks of (p+1) clocks each.
    int m_mode = 0;  // 0 idle, 1 running, 2 done
    int m_k = 0;
    int m_p = 0, m_lv = 0, m_u = 0, m_d = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode  = 0;
            m_k     = 0;
            m_valid = 1'b1;
        end else begin
            case (m_mode)
                0: if (bus.start) begin
                    m_mode = 1;
                    m_k    = 0;
                    m_p    = int'(bus.presc);
                    m_lv   = int'(bus.load_val);
                    m_u    = int'(bus.up_ticks);
                    m_d    = int'(bus.dn_ticks);
                end
                1: begin
                    if (m_k + 1 == (2 + m_u + m_d) * (m_p + 1)) m_mode = 2;
                    else m_k++;
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Downstream 4-bit counter driven by the sequencer's commands.
    logic [3:0] cnt = 4'd0;
    always @(posedge clk) begin
        if (bus.ena) begin
            if (!bus.sclr_n)   cnt <= 4'd0;
            else if (bus.load) cnt <= bus.din;
            else if (bus.dir)  cnt <= cnt - 4'd1;
            else               cnt <= cnt + 4'd1;
        end
    end

    int ena_acc = 0, busy_acc = 0, dir_acc = 0;
    int r_ena = 0, r_busy = 0, r_dir = 0, r_cnt = 0;
    int done_cnt = 0;
    logic [3:0] din_prev = 4'd0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            logic e_ena, e_scl, e_ld, e_dir, e_busy, e_done;
            logic [3:0] e_din;
            int t, ph;
            e_ena = 0; e_scl = 1; e_ld = 0; e_dir = 0; e_busy = 0; e_done = 0;
            e_din = 4'd0;
            if (m_mode == 1) begin
                t      = m_k / (m_p + 1);
                ph     = m_k % (m_p + 1);
                e_ena  = (ph == m_p);
                e_scl  = (t != 0);
                e_ld   = (t == 1);
                e_dir  = (t >= 2 + m_u);
                e_busy = 1'b1;
                e_din  = m_lv[3:0];
            end else if (m_mode == 2) begin
                e_done = 1'b1;
            end
            checks++;
            if ({bus.ena, bus.sclr_n, bus.load, bus.dir, bus.din, bus.busy, bus.done} !==
                {e_ena, e_scl, e_ld, e_dir, e_din, e_busy, e_done}) begin
                errors++;
                $display("FAIL outputs mode=%0d k=%0d got ena=%b sclr_n=%b load=%b dir=%b din=%0d busy=%b done=%b want ena=%b sclr_n=%b load=%b dir=%b din=%0d busy=%b done=%b",
                         m_mode, m_k, bus.ena, bus.sclr_n, bus.load, bus.dir, bus.din, bus.busy, bus.done,
                         e_ena, e_scl, e_ld, e_dir, e_din, e_busy, e_done);
            end
            if (bus.ena) begin
                checks++;
                if (!bus.busy || ($countones({~bus.sclr_n, bus.load}) > 1)) begin
                    errors++;
                    $display("FAIL ena_cmd got busy=%b sclr_n=%b load=%b want busy=1 and one command",
                             bus.busy, bus.sclr_n, bus.load);
                end
            end
            if (bus.busy && busy_prev) begin
                checks++;
                if (bus.din !== din_prev) begin
                    errors++;
                    $display("FAIL din_stable got %0d want %0d", bus.din, din_prev);
                end
            end
        end
        busy_prev = bus.busy;
        din_prev  = bus.din;
        if (bus.busy) begin
            busy_acc++;
            if (bus.ena) ena_acc++;
            if (bus.dir) dir_acc++;
        end else begin
            if (bus.done) begin
                r_ena  = ena_acc;
                r_busy = busy_acc;
                r_dir  = dir_acc;
                r_cnt  = int'(cnt);
                done_cnt++;
            end
            ena_acc  = 0;
            busy_acc = 0;
            dir_acc  = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic wait_done(input int dc0, input string nm);
        int n;
        n = 0;
        while (done_cnt == dc0 && n < 400) begin
            cyc(1);
            n++;
        end
        if (done_cnt == dc0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no done want done pulse", nm);
        end
    endtask

    task automatic set_cfg(input logic [3:0] p, lv, u, d);
        bus.presc    = p;
        bus.load_val = lv;
        bus.up_ticks = u;
        bus.dn_ticks = d;
    endtask

    task automatic do_run(input logic [3:0] p, lv, u, d,
                          input int exp_ena, exp_busy, exp_cnt, input string nm);
        int dc0;
        dc0 = done_cnt;
        set_cfg(p, lv, u, d);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        wait_done(dc0, nm);
        chk({nm, "_ena"},  r_ena,  exp_ena);
        chk({nm, "_busy"}, r_busy, exp_busy);
        chk({nm, "_cnt"},  r_cnt,  exp_cnt);
    endtask

    initial begin
        int dc0;
        int n;
        bus.start = 1'b0;
        set_cfg(4'd0, 4'd0, 4'd0, 4'd0);
        cyc(3);
        chk("reset_outs", int'({bus.ena, bus.sclr_n, bus.load, bus.dir, bus.din, bus.busy, bus.done}),
            int'(10'b01_0000_0000) << 0 >> 0);
        rst = 1'b0;
        cyc(2);

        do_run(4'd2, 4'd5, 4'd3, 4'd2, 7, 21, 6, "r1");
        cyc(2);
        do_run(4'd0, 4'd14, 4'd4, 4'd0, 6, 6, 2, "r2");
        chk("r2_dir", r_dir, 0);
        cyc(2);
        do_run(4'd1, 4'd9, 4'd0, 4'd0, 2, 4, 9, "r3");
        chk("r3_dir", r_dir, 0);
        cyc(2);

        // start held high all run long while the configuration keeps changing
        dc0 = done_cnt;
        set_cfg(4'd1, 4'd3, 4'd1, 4'd2);
        bus.start = 1'b1;
        n = 0;
        while (done_cnt == dc0 && n < 400) begin
            cyc(1);
            set_cfg(4'(n * 3 + 5), 4'(n + 7), 4'(n * 5 + 2), 4'(n + 1));
            n++;
        end
        chk("r4_done_seen", done_cnt - dc0, 1);
        chk("r4_ena",  r_ena,  5);
        chk("r4_busy", r_busy, 10);
        chk("r4_cnt",  r_cnt,  2);
        dc0 = done_cnt;
        set_cfg(4'd0, 4'd2, 4'd2, 4'd0);
        cyc(1);
        bus.start = 1'b0;
        chk("r4b_started", int'(bus.busy), 1);
        wait_done(dc0, "r4b");
        chk("r4b_ena",  r_ena,  4);
        chk("r4b_busy", r_busy, 4);
        chk("r4b_cnt",  r_cnt,  4);
        cyc(2);

        // reset two clocks into the first UP tick
        set_cfg(4'd3, 4'd1, 4'd5, 4'd1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(9);
        chk("r5_in_up", int'({bus.busy, bus.sclr_n, bus.load, bus.dir}), 4'b1100);
        dc0 = done_cnt;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("r5_abort_outs", int'({bus.ena, bus.sclr_n, bus.load, bus.dir, bus.din, bus.busy, bus.done}),
            int'(10'b01_0000_0000));
        cyc(40);
        chk("r5_no_done", done_cnt - dc0, 0);

        // reset wins over a simultaneous start
        set_cfg(4'd0, 4'd1, 4'd0, 4'd3);
        rst = 1'b1;
        bus.start = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.start = 1'b0;
        chk("r6_rst_start_idle", int'(bus.busy), 0);
        cyc(1);
        chk("r6_still_idle", int'({bus.busy, bus.done}), 0);
        do_run(4'd0, 4'd1, 4'd0, 4'd3, 5, 5, 14, "r6");
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
